// File: rtl/csr_timer_bank.sv
// csr_timer_bank
//   A bank of NUM_TIMERS countdown timers with a shared prescaler and a
//   free-running stable counter. It sits beside the core CSR file on the same
//   write port.
//
//   Register map for channel i, with A = BASE_NUM + 4*i:
//     A+0  TCFG   read/write: [0] En, [1] Periodic, [TIMER_WIDTH-1:2] InitVal
//     A+1  TVAL   read-only current count
//     A+2  TICLR  write 1 to bit 0 to clear the pending bit; always reads 0
//     A+3  not mapped
//
//   Ports
//     clk, reset                   clock and synchronous active-high reset
//     csrnum_r -> csrout/csr_hit_r combinational read port
//     csrnum_w, csrwe, csrme,
//     musk, csrin                  write port; csrme=1 selects a masked write
//     ti_pending / ti_any          per-channel interrupt pending bits, and their OR
//     counter_higher/lower         registered copy of the stable counter
module csr_timer_bank #(
    parameter int          NUM_TIMERS  = 4,
    parameter int          TIMER_WIDTH = 32,
    parameter int          CNT_WIDTH   = 64,
    parameter int          PRESCALE    = 1,
    parameter logic [13:0] BASE_NUM    = 14'h41
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [13:0]           csrnum_r,
    output logic [31:0]           csrout,
    output logic                  csr_hit_r,
    input  logic [13:0]           csrnum_w,
    input  logic                  csrwe,
    input  logic                  csrme,
    input  logic [31:0]           musk,
    input  logic [31:0]           csrin,
    output logic [NUM_TIMERS-1:0] ti_pending,
    output logic                  ti_any,
    output logic [31:0]           counter_higher,
    output logic [31:0]           counter_lower
);

    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    // Bits set in the mask take the new data; cleared bits keep the old value.
    function automatic logic [31:0] masked_merge(input logic [31:0] new_v,
                                                 input logic [31:0] old_v,
                                                 input logic [31:0] mask_v);
        return (new_v & mask_v) | (old_v & ~mask_v);
    endfunction

    logic [NUM_TIMERS-1:0][TIMER_WIDTH-1:0] tcfg_q, tcfg_d;
    logic [NUM_TIMERS-1:0][TIMER_WIDTH-1:0] tval_q, tval_d;
    logic [NUM_TIMERS-1:0]                  pend_q, pend_d;
    logic [PSC_W-1:0]                       psc_q, psc_d;
    logic [CNT_WIDTH-1:0]                   cnt_q, cnt_out_q;

    logic                                   tick_s;
    logic [31:0]                            wmask_s;
    logic [NUM_TIMERS-1:0]                  tcfg_we_s;
    logic [NUM_TIMERS-1:0]                  clr_s;
    logic [NUM_TIMERS-1:0][31:0]            wd_cfg_s;

    // With PRESCALE=1, PSC_LAST is 0, so the tick fires every cycle.
    assign tick_s  = (psc_q == PSC_LAST);
    assign wmask_s = csrme ? musk : 32'hFFFF_FFFF;

    // Prescaler next state: counts 0..PRESCALE-1, then wraps to 0.
    always_comb begin
        psc_d = (psc_q == PSC_LAST) ? {PSC_W{1'b0}} : psc_q + PSC_W'(1);
    end

    // Write decode, and the merged TCFG write data for each channel.
    always_comb begin
        tcfg_we_s = '0;
        clr_s     = '0;
        wd_cfg_s  = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            tcfg_we_s[i] = csrwe && (csrnum_w == BASE_NUM + 14'(4 * i));
            // TICLR reads as 0, so masked bits merge against 0.
            clr_s[i]     = csrwe && (csrnum_w == BASE_NUM + 14'(4 * i + 2))
                           && csrin[0] && wmask_s[0];
            wd_cfg_s[i]  = masked_merge(csrin, 32'(tcfg_q[i]), wmask_s);
        end
    end

    // Per-channel next state. A TCFG write beats the countdown.
    // An expiry in the same cycle as a TICLR write keeps the pending bit set.
    always_comb begin
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        pend_d = pend_q;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            pend_d[i] = pend_q[i] & ~clr_s[i];
            if (tcfg_we_s[i]) begin
                tcfg_d[i] = wd_cfg_s[i][TIMER_WIDTH-1:0];
                tval_d[i] = {wd_cfg_s[i][TIMER_WIDTH-1:2], 2'b00};
            end else if (!tcfg_q[i][0]) begin
                tval_d[i] = tval_q[i];
            end else if (tick_s && (tval_q[i] == TIMER_WIDTH'(1))) begin
                pend_d[i] = 1'b1;
                tval_d[i] = tcfg_q[i][1] ? {tcfg_q[i][TIMER_WIDTH-1:2], 2'b00}
                                         : {TIMER_WIDTH{1'b0}};
            end else if (tick_s && (tval_q[i] > TIMER_WIDTH'(1))) begin
                tval_d[i] = tval_q[i] - TIMER_WIDTH'(1);
            end else begin
                // A TVAL of 0 is parked: no interrupt, and no wrap to all-ones.
                tval_d[i] = tval_q[i];
            end
        end
    end

    // Read mux. Any address this bank does not decode reads 0 with no hit.
    always_comb begin
        csrout    = 32'h0000_0000;
        csr_hit_r = 1'b0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            case (csrnum_r - (BASE_NUM + 14'(4 * i)))
                14'd0: begin
                    csr_hit_r = 1'b1;
                    csrout    = 32'(tcfg_q[i]);
                end
                14'd1: begin
                    csr_hit_r = 1'b1;
                    csrout    = 32'(tval_q[i]);
                end
                14'd2: begin
                    csr_hit_r = 1'b1;
                    csrout    = 32'h0000_0000;
                end
                default: begin
                    csr_hit_r = csr_hit_r;
                end
            endcase
        end
    end

    // Timer state registers and prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg_q <= '0;
            tval_q <= '0;
            pend_q <= '0;
            psc_q  <= '0;
        end else begin
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            pend_q <= pend_d;
            psc_q  <= psc_d;
        end
    end

    // Stable counter, plus the registered copy that drives the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            cnt_out_q <= '0;
        end else begin
            cnt_q     <= cnt_q + CNT_WIDTH'(1);
            cnt_out_q <= cnt_q;
        end
    end

    assign ti_pending     = pend_q;
    assign ti_any         = |pend_q;
    assign counter_lower  = cnt_out_q[31:0];
    assign counter_higher = 32'(cnt_out_q[CNT_WIDTH-1:32]);

endmodule

// File: tb/tb_csr_timer_bank.sv
module tb_csr_timer_bank;

    localparam logic [13:0] B = 14'h41;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] csrnum_r, csrnum_w;
    logic        csrwe1, csrwe2, csrme;
    logic [31:0] musk, csrin;

    logic [31:0] csrout1, csrout2, hi1, lo1, hi2, lo2;
    logic        hit1, hit2, any1, any2;
    logic [3:0]  pend1, pend2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] exp;
        string       name;
    } chk_t;
    chk_t sb_q[$];

    csr_timer_bank dut1 (
        .clk(clk), .reset(reset), .csrnum_r(csrnum_r), .csrout(csrout1), .csr_hit_r(hit1),
        .csrnum_w(csrnum_w), .csrwe(csrwe1), .csrme(csrme), .musk(musk), .csrin(csrin),
        .ti_pending(pend1), .ti_any(any1), .counter_higher(hi1), .counter_lower(lo1)
    );

    csr_timer_bank #(.PRESCALE(4)) dut2 (
        .clk(clk), .reset(reset), .csrnum_r(csrnum_r), .csrout(csrout2), .csr_hit_r(hit2),
        .csrnum_w(csrnum_w), .csrwe(csrwe2), .csrme(csrme), .musk(musk), .csrin(csrin),
        .ti_pending(pend2), .ti_any(any2), .counter_higher(hi2), .counter_lower(lo2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] actual(input int kind);
        case (kind)
            0:       return 64'(csrout1);
            1:       return 64'(hit1);
            2:       return 64'(pend1);
            3:       return 64'(any1);
            4:       return 64'(lo1);
            5:       return 64'(hi1);
            6:       return 64'(pend2);
            7:       return 64'(csrout2);
            default: return 64'hDEAD;
        endcase
    endfunction

    // Monitor: at each falling edge, compare every expectation queued for this cycle.
    always @(negedge clk) begin
        chk_t        e;
        logic [63:0] act;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e   = sb_q.pop_front();
            act = actual(e.kind);
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_v(input int kind, input logic [63:0] v, input string nm);
        chk_t e;
        e.cyc = cyc; e.kind = kind; e.exp = v; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a write for one cycle; it lands on the next rising edge.
    task automatic wr(input logic [13:0] num, input logic [31:0] d, input logic me,
                      input logic [31:0] m, input logic second);
        csrnum_w = num; csrin = d; csrme = me; musk = m;
        if (second) csrwe2 = 1'b1; else csrwe1 = 1'b1;
        step(1);
        csrwe1 = 1'b0; csrwe2 = 1'b0;
    endtask

    task automatic rd(input logic [13:0] num, input logic [31:0] v, input logic h,
                      input string nm);
        csrnum_r = num;
        expect_v(0, 64'(v), nm);
        expect_v(1, 64'(h), {nm, "_hit"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; csrnum_r = '0; csrnum_w = '0; csrwe1 = 1'b0; csrwe2 = 1'b0;
        csrme = 1'b0; musk = '0; csrin = '0;
        step(3);
        expect_v(2, 64'h0, "rst_pend");
        expect_v(4, 64'h0, "rst_lo");
        expect_v(5, 64'h0, "rst_hi");
        rd(B, 32'h0, 1'b1, "rst_tcfg0");

        // Prescaler of 4, starting from phase 0 after reset. Channel 2 TCFG = 0x5
        // gives TVAL 4. Ticks fall on write edge +3, +7, +11 and +15, so the
        // expiry lands on edge +15.
        reset = 1'b0;
        wr(B + 14'd8, 32'h5, 1'b0, 32'h0, 1'b1);
        step(14);
        expect_v(6, 64'h0, "t5_pend_before");
        csrnum_r = B + 14'd9;
        expect_v(7, 64'h1, "t5_tval_one");
        step(1);
        expect_v(6, 64'h4, "t5_pend_set");
        expect_v(7, 64'h0, "t5_tval_zero");

        // One-shot on channel 0: TVAL 16, so it expires on write edge +16.
        wr(B, 32'h11, 1'b0, 32'h0, 1'b0);
        rd(B + 14'd1, 32'h10, 1'b1, "t1_tval_load");
        step(15);
        expect_v(2, 64'h0, "t1_pend_before");
        step(1);
        expect_v(2, 64'h1, "t1_pend_set");
        expect_v(3, 64'h1, "t1_any");
        rd(B + 14'd1, 32'h0, 1'b1, "t1_tval_done");
        wr(B + 14'd2, 32'h1, 1'b0, 32'h0, 1'b0);
        expect_v(2, 64'h0, "t1_cleared");
        step(20);
        expect_v(2, 64'h0, "t1_no_second");
        expect_v(3, 64'h0, "t1_any_low");
        rd(B + 14'd1, 32'h0, 1'b1, "t1_tval_stays0");

        // Periodic channel 1: TVAL 8, expiring every 8 ticks.
        wr(B + 14'd4, 32'hB, 1'b0, 32'h0, 1'b0);
        step(7);
        expect_v(2, 64'h0, "t2_before");
        step(1);
        expect_v(2, 64'h2, "t2_first");
        rd(B + 14'd5, 32'h8, 1'b1, "t2_reload");
        wr(B + 14'd6, 32'h1, 1'b0, 32'h0, 1'b0);
        expect_v(2, 64'h0, "t2_cleared");
        step(6);
        expect_v(2, 64'h0, "t2_still_clear");
        step(1);
        expect_v(2, 64'h2, "t2_second");

        // A TICLR write on the same edge as the next expiry (+24) leaves pending set.
        step(7);
        wr(B + 14'd6, 32'h1, 1'b0, 32'h0, 1'b0);
        expect_v(2, 64'h2, "t4_pend_kept");
        rd(B + 14'd6, 32'h0, 1'b1, "t4_ticlr_read");

        // A masked write with musk=1 and csrin=0 clears only En, giving TCFG 0xA
        // with TVAL reloaded to 8.
        wr(B + 14'd4, 32'h0, 1'b1, 32'h1, 1'b0);
        rd(B + 14'd4, 32'hA, 1'b1, "t3_tcfg");
        step(10);
        rd(B + 14'd5, 32'h8, 1'b1, "t3_tval_frozen");
        expect_v(2, 64'h2, "t3_pend_held");
        wr(B + 14'd5, 32'h40, 1'b0, 32'h0, 1'b0);
        rd(B + 14'd5, 32'h8, 1'b1, "tval_write_ignored");

        // Stable counter crossing 32 bits; its outputs lag by one cycle.
        force dut1.cnt_q = 64'hFFFF_FFFF;
        #1;
        release dut1.cnt_q;
        step(1);
        expect_v(4, 64'hFFFF_FFFF, "t6_lo_pre");
        expect_v(5, 64'h0, "t6_hi_pre");
        step(1);
        expect_v(4, 64'h0, "t6_lo_wrap");
        expect_v(5, 64'h1, "t6_hi_carry");
        rd(B + 14'd3, 32'h0, 1'b0, "t6_unmapped");
        rd(14'h0, 32'h0, 1'b0, "far_unmapped");

        // Reset takes priority over a TCFG write in the same cycle.
        reset = 1'b1;
        wr(B, 32'h11, 1'b0, 32'h0, 1'b0);
        rd(B, 32'h0, 1'b1, "rst_over_write");
        expect_v(2, 64'h0, "rst_mid_pend");
        expect_v(4, 64'h0, "rst_mid_lo");
        reset = 1'b0;

        step(3);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
